// File: rtl/rcs_byte_frontend_pkg.sv
// Shared definitions for the byte-serial subtractor front end: widths and FSM state encodings.
package rcs_byte_frontend_pkg;
    localparam int RCS_W      = 16;
    localparam int RCS_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_A0   = 3'd0,
        S_A1   = 3'd1,
        S_B0   = 3'd2,
        S_B1   = 3'd3,
        S_CALC = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    function automatic logic is_load_state(input state_t s);
        return (s == S_A0) || (s == S_A1) || (s == S_B0) || (s == S_B1);
    endfunction
endpackage

// File: rtl/rcs_16bit.sv
// 16-bit ripple-carry subtractor: diff = a + ~b + carry_start.
// Latency: combinational.
// Backpressure: none; pure datapath.
module rcs_16bit
    import rcs_byte_frontend_pkg::*;
(
    input  logic [RCS_W-1:0] a,
    input  logic [RCS_W-1:0] b,
    input  logic             carry_start,
    output logic [RCS_W-1:0] diff,
    output logic             carry_out
);
    logic [RCS_W:0] c;
    logic [RCS_W-1:0] nb;

    assign nb = ~b;

    always_comb begin
        c    = '0;
        diff = '0;
        c[0] = carry_start;
        for (int i = 0; i < RCS_W; i++) begin
            diff[i]  = a[i] ^ nb[i] ^ c[i];
            c[i+1]   = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
        end
    end

    assign carry_out = c[RCS_W];
endmodule

// File: rtl/rcs_byte_frontend.sv
// Collects A and B as four bytes, computes A - B and holds the result (optional out_ovf: RCS_OVF_EN).
// Latency: result valid one S_CALC cycle after the edge accepting the 4th byte.
// Backpressure: in_ready low in S_CALC/S_OUT; result held until out_ready.
module rcs_byte_frontend
    import rcs_byte_frontend_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 0,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [RCS_BYTE_W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [RCS_W-1:0]      out_diff,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_timeout,
    output logic                  busy
`ifdef RCS_OVF_EN
    ,
    output logic                  out_ovf
`endif
);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [RCS_W-1:0] a_q;
    logic [RCS_W-1:0] b_q;
    logic [RCS_W-1:0] sub_diff;
    logic             sub_carry;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign in_ready = is_load_state(state);
    assign busy     = (state != S_A0);
    assign accept   = in_valid & in_ready;

    rcs_16bit u_sub (
        .a           (a_q),
        .b           (b_q),
        .carry_start (1'b1),
        .diff        (sub_diff),
        .carry_out   (sub_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A0;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            out_diff    <= '0;
            out_carry   <= 1'b0;
            out_zero    <= 1'b0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
`ifdef RCS_OVF_EN
            out_ovf     <= 1'b0;
`endif
        end else begin
            err_timeout <= 1'b0;
            if (clr) begin
                state     <= S_A0;
                out_valid <= 1'b0;
                cnt       <= '0;
                a_q       <= '0;
                b_q       <= '0;
            end else if (accept) begin
                cnt <= '0;
                // First byte of each operand lands in the low half when LSB_FIRST, else the high half.
                case (state)
                    S_A0: begin
                        if (LSB_FIRST) a_q[7:0]  <= in_data;
                        else           a_q[15:8] <= in_data;
                        state <= S_A1;
                    end
                    S_A1: begin
                        if (LSB_FIRST) a_q[15:8] <= in_data;
                        else           a_q[7:0]  <= in_data;
                        state <= S_B0;
                    end
                    S_B0: begin
                        if (LSB_FIRST) b_q[7:0]  <= in_data;
                        else           b_q[15:8] <= in_data;
                        state <= S_B1;
                    end
                    default: begin
                        if (LSB_FIRST) b_q[15:8] <= in_data;
                        else           b_q[7:0]  <= in_data;
                        state <= S_CALC;
                    end
                endcase
            end else if (state == S_CALC) begin
                out_diff  <= sub_diff;
                out_carry <= sub_carry;
                out_zero  <= (sub_diff == '0);
`ifdef RCS_OVF_EN
                out_ovf   <= (a_q[15] != b_q[15]) & (sub_diff[15] != a_q[15]);
`endif
                out_valid <= 1'b1;
                state     <= S_OUT;
            end else if (state == S_OUT) begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_A0;
                end
            end else if ((TIMEOUT > 0) && (state != S_A0)) begin
                // Mid-frame idle: abort on the TIMEOUT-th consecutive idle cycle.
                if (cnt == TO_LAST) begin
                    err_timeout <= 1'b1;
                    state       <= S_A0;
                    a_q         <= '0;
                    b_q         <= '0;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state > S_OUT) begin
                state <= S_A0;
            end
        end
    end
endmodule

// File: tb/tb_rcs_byte_frontend.sv
// Directed bench for rcs_byte_frontend: LSB-first instance with TIMEOUT=8, MSB-first instance without timeout.
module tb_rcs_byte_frontend;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic        l_in_ready, m_in_ready, l_out_carry, m_out_carry, l_out_zero, m_out_zero;
    logic        l_out_valid, m_out_valid, l_err, m_err, l_busy, m_busy;
    logic [15:0] l_out_diff, m_out_diff;
`ifdef RCS_OVF_EN
    logic        l_ovf, m_ovf, o_ovf;
    assign o_ovf = sel ? m_ovf : l_ovf;
`endif

    logic        o_in_ready, o_carry, o_zero, o_valid, o_err, o_busy;
    logic [15:0] o_diff;
    assign o_in_ready = sel ? m_in_ready  : l_in_ready;
    assign o_carry    = sel ? m_out_carry : l_out_carry;
    assign o_zero     = sel ? m_out_zero  : l_out_zero;
    assign o_valid    = sel ? m_out_valid : l_out_valid;
    assign o_err      = sel ? m_err       : l_err;
    assign o_busy     = sel ? m_busy      : l_busy;
    assign o_diff     = sel ? m_out_diff  : l_out_diff;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rcs_byte_frontend #(.LSB_FIRST(1'b1), .TIMEOUT(8), .CNT_W(8)) u_dut_l (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data),
        .in_valid(in_valid & ~sel), .in_ready(l_in_ready),
        .out_diff(l_out_diff), .out_carry(l_out_carry), .out_zero(l_out_zero),
        .out_valid(l_out_valid), .out_ready(out_ready & ~sel),
        .err_timeout(l_err), .busy(l_busy)
`ifdef RCS_OVF_EN
        , .out_ovf(l_ovf)
`endif
    );

    rcs_byte_frontend #(.LSB_FIRST(1'b0), .TIMEOUT(0), .CNT_W(8)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data),
        .in_valid(in_valid & sel), .in_ready(m_in_ready),
        .out_diff(m_out_diff), .out_carry(m_out_carry), .out_zero(m_out_zero),
        .out_valid(m_out_valid), .out_ready(out_ready & sel),
        .err_timeout(m_err), .busy(m_busy)
`ifdef RCS_OVF_EN
        , .out_ovf(m_ovf)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] d);
        int k;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        k = 0;
        while (!o_in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("accept_bound", (k < 20), 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic lsb, input logic [15:0] ed, input logic ec,
                             input logic ez, input logic eo);
        if (lsb) begin
            send_byte(a[7:0]);  send_byte(a[15:8]); send_byte(b[7:0]);  send_byte(b[15:8]);
        end else begin
            send_byte(a[15:8]); send_byte(a[7:0]);  send_byte(b[15:8]); send_byte(b[7:0]);
        end
        check_val({tag, "_calc_nvld"}, o_valid, 1'b0);
        check_val({tag, "_calc_rdy"}, o_in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_val({tag, "_vld"}, o_valid, 1'b1);
        check_val({tag, "_diff"}, o_diff, ed);
        check_val({tag, "_carry"}, o_carry, ec);
        check_val({tag, "_zero"}, o_zero, ez);
`ifdef RCS_OVF_EN
        check_val({tag, "_ovf"}, o_ovf, eo);
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_consumed"}, o_valid, 1'b0);
        check_val({tag, "_idle_rdy"}, o_in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_vld", o_valid, 1'b0);
        check_val("rst_diff", o_diff, 16'h0000);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_rdy", o_in_ready, 1'b1);
        check_val("rst_err", o_err, 1'b0);
        rst_n = 1'b1;

        run_frame("f1", 16'h1234, 16'h5678, 1'b1, 16'hBBBC, 1'b0, 1'b0, 1'b0);
        consume("f1");

        // Async reset mid-frame discards the partial frame.
        send_byte(8'h00);
        send_byte(8'h11);
        check_val("mid_busy", o_busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_vld", o_valid, 1'b0);
        check_val("arst_diff", o_diff, 16'h0000);
        check_val("arst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("f2", 16'h5678, 16'h1234, 1'b1, 16'h4444, 1'b1, 1'b0, 1'b0);
        consume("f2");

        // Backpressure: result held, no bytes taken while out_ready is low.
        run_frame("f3", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_vld", o_valid, 1'b1);
            check_val("bp_diff", o_diff, 16'h0000);
            check_val("bp_rdy", o_in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("f3");

        // Timeout after 2 bytes and 8 idle cycles.
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (7) @(posedge clk);
        #1;
        check_val("to_pre_err", o_err, 1'b0);
        check_val("to_pre_busy", o_busy, 1'b1);
        @(posedge clk);
        #1;
        check_val("to_err", o_err, 1'b1);
        check_val("to_busy", o_busy, 1'b0);
        @(posedge clk);
        #1;
        check_val("to_err_pulse", o_err, 1'b0);
        run_frame("f4", 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        consume("f4");

        // clr mid-frame: frame dropped, no timeout pulse.
        send_byte(8'h77);
        send_byte(8'h66);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_val("clr_busy", o_busy, 1'b0);
        check_val("clr_err", o_err, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check_val("clr_no_err", o_err, 1'b0);
        run_frame("f5", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        consume("f5");

        run_frame("f6", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        consume("f6");
        run_frame("f7", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1);
        consume("f7");

        // MSB-first instance.
        @(negedge clk);
        sel = 1'b1;
        run_frame("m1", 16'h1234, 16'h5678, 1'b0, 16'hBBBC, 1'b0, 1'b0, 1'b0);
        consume("m1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
